// File: rtl/bus_pkg.sv
// Shared definitions for the bus write buffer: default word geometry and the
// controller state encoding.
package bus_pkg;

    // Widest serial word in bits, and the width of a bit-count field able to hold it.
    localparam int BUS_MAX_DATA_SIZE   = 9;
    localparam int BUS_DATA_SIZE_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2
    } bus_state_t;

endpackage

// File: rtl/bus_write_buffer_edge_detector.sv
// One-bit registered edge detector: compares the live input with a copy
// delayed by one sys_clk to flag rising and falling edges.
module edge_detector #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_prev;

    // Hold the previous-cycle value of the input.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            sig_prev <= RESET_VAL;
        end else begin
            sig_prev <= sig;
        end
    end

    assign rise = sig & ~sig_prev;
    assign fall = ~sig & sig_prev;

endmodule

// File: rtl/bus_write_buffer.sv
// Bus write buffer: shifts a parallel word out MSB-first, paced by an already
// synchronised bus SCK, or passes the far-side serial line straight through.
// Optional feature macro: BUS_WRITE_ABORT_ON_CS_EN -- when defined, a rising
// edge on bus_cs_n during a transfer aborts it; otherwise bus_cs_n is ignored.
// Handshake: send is a one-cycle strobe honoured only while done=1 (IDLE);
// done drops on the cycle after an accepted send and returns to 1 the cycle
// after the final counted SCK rise.
module bus_write_buffer
    import bus_pkg::*;
#(
    parameter int MAX_DATA_SIZE   = BUS_MAX_DATA_SIZE,
    parameter int DATA_SIZE_WIDTH = BUS_DATA_SIZE_WIDTH
) (
    input  logic                       sys_clk,
    input  logic                       rst_n,
    input  logic                       bus_clk,
    input  logic                       bus_cs_n,
    input  logic                       send,
    input  logic [DATA_SIZE_WIDTH-1:0] data_size,
    input  logic [MAX_DATA_SIZE-1:0]   data_in,
    input  logic                       fake_select,
    input  logic                       real_in,
    output logic                       data_out,
    output logic                       done,
    output bus_state_t                 state_dbg
);

    localparam logic [DATA_SIZE_WIDTH-1:0] SIZE_MAX = DATA_SIZE_WIDTH'(MAX_DATA_SIZE);
    localparam logic [DATA_SIZE_WIDTH-1:0] SIZE_ONE = DATA_SIZE_WIDTH'(1);

    bus_state_t                 state, state_n;
    logic                       done_n;
    logic [MAX_DATA_SIZE-1:0]   shreg, shreg_n;
    logic [DATA_SIZE_WIDTH-1:0] count, count_n;
    logic                       sel_q, sel_n;
    logic                       seen_rise, seen_n;
    logic [DATA_SIZE_WIDTH-1:0] size_clamped;
    logic                       clk_rise, clk_fall;
    logic                       cs_rise, cs_fall;
    logic                       cs_edges_unused;

    edge_detector #(.RESET_VAL(1'b0)) u_clk_edge (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .sig     (bus_clk),
        .rise    (clk_rise),
        .fall    (clk_fall)
    );

    // Chip select idles high, so its history starts high to avoid a false rise.
    edge_detector #(.RESET_VAL(1'b1)) u_cs_edge (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .sig     (bus_cs_n),
        .rise    (cs_rise),
        .fall    (cs_fall)
    );

`ifdef BUS_WRITE_ABORT_ON_CS_EN
    assign cs_edges_unused = cs_fall;
`else
    assign cs_edges_unused = cs_rise | cs_fall;
`endif

    // Oversized requests are trimmed to the widest word the register holds.
    assign size_clamped = (data_size > SIZE_MAX) ? SIZE_MAX : data_size;

    // State and datapath registers.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state     <= ST_RESET;
            done      <= 1'b0;
            shreg     <= '0;
            count     <= '0;
            sel_q     <= 1'b0;
            seen_rise <= 1'b0;
        end else begin
            state     <= state_n;
            done      <= done_n;
            shreg     <= shreg_n;
            count     <= count_n;
            sel_q     <= sel_n;
            seen_rise <= seen_n;
        end
    end

    // Next-state logic: load on send, count on SCK rise, shift on SCK fall.
    always_comb begin
        state_n = state;
        done_n  = done;
        shreg_n = shreg;
        count_n = count;
        sel_n   = sel_q;
        seen_n  = seen_rise;
        case (state)
            ST_RESET: begin
                state_n = ST_IDLE;
                done_n  = 1'b1;
            end
            ST_IDLE: begin
                // A rise coinciding with send is consumed by the load, not counted.
                if (send && (data_size != '0)) begin
                    shreg_n = data_in;
                    count_n = size_clamped;
                    sel_n   = fake_select;
                    seen_n  = 1'b0;
                    done_n  = 1'b0;
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (clk_rise) begin
                    count_n = count - SIZE_ONE;
                    seen_n  = 1'b1;
                    if (count == SIZE_ONE) begin
                        done_n  = 1'b1;
                        state_n = ST_IDLE;
                    end
                end else if (clk_fall && seen_rise && (count != '0)) begin
                    // A fall before the first rise would discard the MSB unsent.
                    shreg_n = {shreg[MAX_DATA_SIZE-2:0], 1'b0};
                end
`ifdef BUS_WRITE_ABORT_ON_CS_EN
                if (cs_rise) begin
                    shreg_n = '0;
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end
`endif
            end
            default: begin
                state_n = ST_RESET;
            end
        endcase
    end

    assign data_out  = ((state == ST_SHIFT) && sel_q) ? shreg[MAX_DATA_SIZE-1] : real_in;
    assign state_dbg = state;

endmodule

// File: tb/tb_bus_write_buffer.sv
// Self-checking bench for bus_write_buffer. Expected serial bits come from a
// queue built straight from data_in (MSB first, length = clamped size).
module tb_bus_write_buffer;
    import bus_pkg::*;

    localparam int MAXB = 9;

    logic       sys_clk     = 1'b0;
    logic       rst_n       = 1'b0;
    logic       bus_clk     = 1'b0;
    logic       bus_cs_n    = 1'b1;
    logic       send        = 1'b0;
    logic [3:0] data_size   = 4'd0;
    logic [8:0] data_in     = 9'd0;
    logic       fake_select = 1'b0;
    logic       real_in     = 1'b0;
    logic       data_out;
    logic       done;
    bus_state_t state_dbg;

    int   errors = 0;
    int   checks = 0;
    logic exp_q[$];

    // Clock and DUT.
    always #5 sys_clk = ~sys_clk;

    bus_write_buffer dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .bus_clk     (bus_clk),
        .bus_cs_n    (bus_cs_n),
        .send        (send),
        .data_size   (data_size),
        .data_in     (data_in),
        .fake_select (fake_select),
        .real_in     (real_in),
        .data_out    (data_out),
        .done        (done),
        .state_dbg   (state_dbg)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode: 0 plain, 1 fall before first rise, 2 rise together with send,
    //       3 extra send issued mid-transfer.
    task automatic do_transfer(input logic [8:0] d, input logic [3:0] sz, input logic sel,
                               input int mode, input int abort_after, input int reset_after);
        int   n;
        logic exp_bit;
        n = (sz > 4'd9) ? MAXB : int'(sz);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(d[MAXB-1-i]);

        if (mode == 1) begin
            @(negedge sys_clk);
            bus_clk = 1'b1;
            @(negedge sys_clk);
        end
        @(negedge sys_clk);
        data_in = d; data_size = sz; fake_select = sel; send = 1'b1; bus_cs_n = 1'b0;
        if (mode == 2) bus_clk = 1'b1;
        @(negedge sys_clk);
        send = 1'b0;
        real_in = 1'($urandom_range(0, 1));
        #1;
        if (n == 0) begin
            check("size0_done", 16'(done), 16'(1'b1));
            check("size0_state", 16'(state_dbg), 16'(ST_IDLE));
            check("size0_out", 16'(data_out), 16'(real_in));
            bus_cs_n = 1'b1;
            return;
        end
        check("load_done", 16'(done), 16'(1'b0));
        check("load_out", 16'(data_out), 16'(sel ? exp_q[0] : real_in));
        if (mode == 1 || mode == 2) begin
            bus_clk = 1'b0;
            @(negedge sys_clk);
            @(negedge sys_clk);
            real_in = 1'($urandom_range(0, 1));
            #1;
            check("early_fall_out", 16'(data_out), 16'(sel ? exp_q[0] : real_in));
        end

        for (int i = 0; i < n; i++) begin
            exp_bit = exp_q.pop_front();
            bus_clk = 1'b1;
            real_in = 1'($urandom_range(0, 1));
            #1;
            check("rise_bit", 16'(data_out), 16'(sel ? exp_bit : real_in));
            if (mode == 3 && i == 1 && n > 2) begin
                data_in = ~d; data_size = 4'd5; fake_select = ~sel; send = 1'b1;
            end
            @(negedge sys_clk);
            send = 1'b0;
            real_in = 1'($urandom_range(0, 1));
            #1;
            if (i == n - 1) begin
                check("done_after_last", 16'(done), 16'(1'b1));
                check("idle_out", 16'(data_out), 16'(real_in));
            end else begin
                check("mid_done", 16'(done), 16'(1'b0));
                check("hold_bit", 16'(data_out), 16'(sel ? exp_bit : real_in));
            end
            if (reset_after == i + 1) begin
                rst_n = 1'b0;
                @(negedge sys_clk);
                #1;
                check("rst_done", 16'(done), 16'(1'b0));
                check("rst_state", 16'(state_dbg), 16'(ST_RESET));
                check("rst_out", 16'(data_out), 16'(real_in));
                rst_n = 1'b1;
                #1;
                check("rel_done_low", 16'(done), 16'(1'b0));
                @(negedge sys_clk);
                #1;
                check("rel_done_high", 16'(done), 16'(1'b1));
                check("rel_state", 16'(state_dbg), 16'(ST_IDLE));
                for (int k = 0; k < 4; k++) begin
                    bus_clk = ~bus_clk;
                    real_in = 1'($urandom_range(0, 1));
                    @(negedge sys_clk);
                    #1;
                    check("post_rst_out", 16'(data_out), 16'(real_in));
                end
                bus_clk = 1'b0;
                bus_cs_n = 1'b1;
                return;
            end
            bus_clk = 1'b0;
            @(negedge sys_clk);
            if (abort_after == i + 1) begin
                bus_cs_n = 1'b1;
                @(negedge sys_clk);
                real_in = 1'($urandom_range(0, 1));
                #1;
`ifdef BUS_WRITE_ABORT_ON_CS_EN
                check("abort_done", 16'(done), 16'(1'b1));
                check("abort_state", 16'(state_dbg), 16'(ST_IDLE));
                check("abort_out", 16'(data_out), 16'(real_in));
                return;
`else
                check("cs_ignored_done", 16'(done), 16'(1'b0));
`endif
            end
        end
        bus_cs_n = 1'b1;
        @(negedge sys_clk);
        #1;
        check("end_done", 16'(done), 16'(1'b1));
        check("end_state", 16'(state_dbg), 16'(ST_IDLE));
    endtask

    // Directed steps, then randomized transfers.
    initial begin
        rst_n = 1'b0;
        real_in = 1'b1;
        repeat (3) @(negedge sys_clk);
        #1;
        check("reset_done", 16'(done), 16'(1'b0));
        check("reset_state", 16'(state_dbg), 16'(ST_RESET));
        check("reset_out_hi", 16'(data_out), 16'(1'b1));
        real_in = 1'b0;
        #1;
        check("reset_out_lo", 16'(data_out), 16'(1'b0));
        rst_n = 1'b1;
        @(negedge sys_clk);
        #1;
        check("release_done", 16'(done), 16'(1'b1));
        check("release_state", 16'(state_dbg), 16'(ST_IDLE));

        do_transfer(9'h048, 4'd8, 1'b1, 0, 0, 0);
        do_transfer(9'h0b3, 4'd3, 1'b0, 0, 0, 0);
        do_transfer(9'h1ff, 4'd0, 1'b1, 0, 0, 0);
        do_transfer(9'h16b, 4'd15, 1'b1, 0, 0, 0);
        do_transfer(9'h1a5, 4'd9, 1'b1, 0, 0, 4);
        do_transfer(9'h0f3, 4'd8, 1'b1, 0, 2, 0);
        do_transfer(9'h155, 4'd9, 1'b1, 1, 0, 0);
        do_transfer(9'h0cc, 4'd6, 1'b1, 2, 0, 0);
        do_transfer(9'h1e1, 4'd7, 1'b1, 3, 0, 0);

        for (int t = 0; t < 16; t++) begin
            do_transfer(9'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                         int'($urandom_range(0, 3)), 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends with a summary.
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_write_buffer.md
BUS_WRITE_BUFFER -- requirements
Module: bus_write_buffer

Interface
REQ-001 SHALL use parameter MAX_DATA_SIZE, default 9, the widest serial word in bits.
REQ-002 SHALL use parameter DATA_SIZE_WIDTH, default 4 (ceil(lg(MAX_DATA_SIZE+1))), the width of the bit-count field.
REQ-003 SHALL have port sys_clk  in  1  system clock; all logic on posedge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port bus_clk  in  1  bus SCK, already synchronised to sys_clk.
REQ-006 SHALL have port bus_cs_n  in  1  bus chip select, already synchronised, active-low.
REQ-007 SHALL have port send  in  1  single-cycle start strobe.
REQ-008 SHALL have port data_size  in  DATA_SIZE_WIDTH  number of bits to transmit.
REQ-009 SHALL have port data_in  in  MAX_DATA_SIZE  parallel word; the first bit sent is bit MAX_DATA_SIZE-1.
REQ-010 SHALL have port fake_select  in  1  1 = drive data_in, 0 = pass real_in through.
REQ-011 SHALL have port real_in  in  1  real serial line value from the far side.
REQ-012 SHALL have port data_out  out  1  serial line driven toward the bus.
REQ-013 SHALL have port done  out  1  high when idle and ready to accept send.

Function
REQ-014 SHALL implement states IDLE, SHIFT and RESET; RESET moves to IDLE after one cycle.
REQ-015 SHALL detect bus_clk edges by comparing against a one-cycle registered copy: rise = cur & ~prev, fall = ~cur & prev.
REQ-016 SHALL, in IDLE with send=1 and data_size>0, load data_in into the shift register, load the count, latch fake_select, clear done and enter SHIFT on the next cycle.
REQ-017 SHALL clamp a data_size above MAX_DATA_SIZE to MAX_DATA_SIZE.
REQ-018 SHALL treat send with data_size=0 as a no-op: done stays 1 and the state stays IDLE.
REQ-019 SHALL ignore send while in SHIFT.
REQ-020 SHALL present the shift-register MSB on data_out from the cycle after the load, before the first bus_clk rise.
REQ-021 SHALL decrement the count on each bus_clk rise in SHIFT.
REQ-022 SHALL left-shift the register by one, zero-filling, on each bus_clk fall in SHIFT while count>0.
REQ-023 SHALL, when a rise brings the count to 0, set done=1 and return to IDLE on the following cycle, one sys_clk of latency.
REQ-024 SHALL drive data_out = shift MSB when in SHIFT with latched select=1, and data_out = real_in combinationally otherwise.
REQ-025 SHALL act on a rise and a send arriving in the same cycle in IDLE by the send only; that rise is not counted.
REQ-026 SHALL take no action on a fall that arrives before the first rise.

Reset
REQ-027 SHALL, with rst_n=0 at a sys_clk edge, enter RESET with done=0, shift register=0, count=0 and latched select=0.
REQ-028 SHALL have done=1 and data_out=real_in one cycle after rst_n returns to 1.
REQ-029 SHALL abandon any transfer on a reset asserted mid-SHIFT, with no further bits driven.

Configuration
REQ-030 SHALL, with BUS_WRITE_ABORT_ON_CS_EN defined, abort a transfer on a bus_cs_n rising edge in SHIFT: return to IDLE, set done=1, clear the shift register, revert data_out to real_in.
REQ-031 SHALL, with BUS_WRITE_ABORT_ON_CS_EN undefined, ignore bus_cs_n entirely; the transfer ends only by count or reset.

Structure
REQ-032 SHALL take MAX_DATA_SIZE, DATA_SIZE_WIDTH and the state encodings from the shared package bus_pkg.
REQ-033 SHALL instantiate one sub-module, edge_detector (1-bit registered rise/fall detect), for bus_clk; bus_cs_n uses a second instance.

Verification
REQ-034 SHALL verify: data_in=9'h048, size=8, select=1, 8 SCK cycles -> data_out shows 0,0,1,0,0,1,0,0 at each rise, then done=1 one cycle after the 8th rise.
REQ-035 SHALL verify: select=0, size=3, real_in toggling -> data_out equals real_in every cycle, and done rises after the 3rd rise.
REQ-036 SHALL verify: size=0 with send -> done stays 1, state stays IDLE, no shift.
REQ-037 SHALL verify: size=15 -> exactly 9 bits sent, then done.
REQ-038 SHALL verify: rst_n=0 after the 4th rise of a 9-bit transfer -> done=0 for one cycle after release, then 1, and data_out=real_in.
REQ-039 SHALL verify, with BUS_WRITE_ABORT_ON_CS_EN defined: bus_cs_n rises after the 2nd of 8 bits -> done=1 the next cycle; when undefined, the transfer completes all 8 bits.
